// File: rtl/microp_pkg.sv
// Shared register-file constants and the write-back entry layout.
package microp_pkg;

  localparam int unsigned REG_DATA_W = 8;
  localparam int unsigned REG_ADDR_W = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_idx;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular write-back queue; also exposes its occupied entries oldest-first
// so the top level can search for forwarding matches.
module wb_fifo
  import microp_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  wb_entry_t             i_entry,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output wb_entry_t             o_head,
  output logic [CNT_W-1:0]      o_count,
  output wb_entry_t [DEPTH-1:0] o_entries,
  output logic [DEPTH-1:0]      o_valid
);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // A full queue refuses pushes even when it pops on the same edge.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_entry;
  end

  always_comb begin
    o_entries = '0;
    o_valid   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_entries[k] = r_mem[r_head + PTR_W'(k)];
      o_valid[k]   = (CNT_W'(k) < r_count);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back buffer in front of the register file: queues writes, commits one
// per cycle and forwards not-yet-committed data to both read ports.
module regfile_writeback
  import microp_pkg::*;
#(
  parameter  int unsigned DATA_W = REG_DATA_W,
  parameter  int unsigned ADDR_W = REG_ADDR_W,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              drain_en,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteR,
  output logic [DATA_W-1:0] WriteD,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [DATA_W-1:0] ReadD1_rf,
  input  logic [DATA_W-1:0] ReadD2_rf,
  output logic [DATA_W-1:0] ReadD1,
  output logic [DATA_W-1:0] ReadD2,
  output logic [CNT_W-1:0]  pending_cnt
);

  wb_entry_t             w_in_entry;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;

  assign w_in_entry.reg_idx = wb_reg;
  assign w_in_entry.data    = wb_data;
  assign wb_ready           = !w_full;
  assign w_pop              = drain_en && !w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_push   (wb_valid),
    .i_entry  (w_in_entry),
    .i_pop    (w_pop),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head),
    .o_count  (pending_cnt),
    .o_entries(w_entries),
    .o_valid  (w_valid)
  );

  // Commit stage: the popped head drives the register-file write port next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite <= 1'b0;
      WriteR   <= '0;
      WriteD   <= '0;
    end else if (w_pop) begin
      RegWrite <= 1'b1;
      WriteR   <= w_head.reg_idx;
      WriteD   <= w_head.data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  // Entries arrive oldest-first, so a later match overrides an earlier one.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rf_data
  );
    logic [DATA_W-1:0] res;
    res = rf_data;
    if (RegWrite && (WriteR == idx)) res = WriteD;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_valid[k] && (w_entries[k].reg_idx == idx)) res = w_entries[k].data;
    end
    return res;
  endfunction

  assign ReadD1 = fwd(Read1, ReadD1_rf);
  assign ReadD2 = fwd(Read2, ReadD2_rf);

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back buffer that sits between the execute/memory stages and the 4x8 register file.
- Accepts register-write requests over a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle onto the register file's write port (RegWrite/WriteR/WriteD).
- Forwards pending (not yet committed) data onto the two read-data paths so decode never sees stale values.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 2, register index width (2^ADDR_W registers).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  write request present.
- wb_ready  out  1  buffer can accept a request; equals !full.
- wb_reg  in  ADDR_W  destination register index.
- wb_data  in  DATA_W  write data.
- drain_en  in  1  permits popping the head entry this cycle.
- RegWrite  out  1  register-file write enable (registered).
- WriteR  out  ADDR_W  register-file write index (registered).
- WriteD  out  DATA_W  register-file write data (registered).
- Read1  in  ADDR_W  read index, port 1 (also drives the register file).
- Read2  in  ADDR_W  read index, port 2.
- ReadD1_rf  in  DATA_W  raw register-file read data, port 1.
- ReadD2_rf  in  DATA_W  raw register-file read data, port 2.
- ReadD1  out  DATA_W  forwarded read data, port 1.
- ReadD2  out  DATA_W  forwarded read data, port 2.
- pending_cnt  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, reset_n=0):
  - Pointers and count cleared; pending_cnt=0.
  - RegWrite=0, WriteR=0, WriteD=0.
  - All queued entries are discarded, including any in progress mid-operation. Nothing is committed after reset.
- Push: on a rising edge with wb_valid && wb_ready, {wb_reg, wb_data} is written at the tail and the tail pointer advances (wraps modulo DEPTH).
- wb_ready is combinational: !(count==DEPTH).
  - Push while full is not accepted; the requester holds its request.
  - No pass-through when full, even if a pop occurs the same cycle.
- Pop: on a rising edge with drain_en && count!=0:
  - Head entry is loaded into WriteR/WriteD and RegWrite<=1.
  - Head pointer advances (wraps).
  - Otherwise RegWrite<=0; WriteR/WriteD hold their previous values.
- Simultaneous push and pop: count unchanged; legal at any occupancy below full, including empty (push and pop target different entries; an empty FIFO pops nothing that edge).
- Latency, empty buffer with drain_en=1:
  - Request accepted at edge N.
  - Popped at edge N+1; RegWrite high during cycle N+1..N+2.
  - Register file updated at edge N+2.
- RegWrite is high for exactly one cycle per popped entry. Back-to-back pops produce a continuous RegWrite with a new WriteR/WriteD each cycle.
- Forwarding, combinational and per read port independently (highest priority first):
  1. Youngest valid FIFO entry whose reg equals the read index.
  2. Older FIFO entries, in age order.
  3. The in-flight write (RegWrite=1 && WriteR equals the read index) → WriteD.
  4. Otherwise the raw register-file data (ReadD1_rf/ReadD2_rf).
- Only occupied entries (between head and tail, count-based) participate in matching; stale slots never forward.
- pending_cnt reflects registered count; it does not include the in-flight write.
- Write-after-write ordering: commits occur strictly in acceptance order. Duplicate indices are not coalesced.

Decomposition:
- Shared package (microp_pkg):
  - REG_DATA_W=8, REG_ADDR_W=2.
  - wb_entry_t struct {reg, data}.
- Sub-module wb_fifo: circular buffer with head/tail/count, push/pop, full/empty, and a flattened entry+valid vector exported for the forwarding search.
- The forwarding mux stays in regfile_writeback.

Test Plan:
- Reset/idle: reset_n=0 mid-stream with 3 entries queued → RegWrite=0, pending_cnt=0, wb_ready=1 immediately; after release no writes are issued.
- Single write: push r0=AA with drain_en=1 → RegWrite=1, WriteR=0, WriteD=AA in the cycle after the pop edge. The register file reads back AA two edges after acceptance.
- Fill/full: drain_en=0, push r0=AA, r1=FF, r2=11, r3=AB → pending_cnt=4, wb_ready=0. A fifth push (r0=55) is not accepted. Then drain_en=1 → four consecutive RegWrite cycles in order AA, FF, 11, AB.
- Forwarding priority: drain_en=0, push r2=11 then r2=22, Read1=2, Read2=3 → ReadD1=22, ReadD2=ReadD2_rf. After the first pop, ReadD1 stays 22 (youngest FIFO entry beats in-flight 11).
- In-flight forward: single entry r1=FF popped; during the RegWrite cycle Read2=1 → ReadD2=FF while ReadD2_rf still returns the old value.
- Simultaneous push/pop at count=3 (DEPTH=4) → count stays 3, wb_ready stays 1, commit order preserved across pointer wrap-around.
